// File: rtl/sseg_frame_monitor.sv
// sseg_frame_monitor: rebuilds multiplexed seven-segment display contents into per-frame snapshots
module sseg_frame_monitor #(
  parameter int N_DIGITS = 4,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            segments,
  input  logic                  dp,
  input  logic [N_DIGITS-1:0]   anodes,
  output logic [4*N_DIGITS-1:0] displayed_num,
  output logic [N_DIGITS-1:0]   dp_out,
  output logic [N_DIGITS-1:0]   blank,
  output logic [N_DIGITS-1:0]   invalid,
  output logic                  frame_valid,
  output logic                  multi_anode_err
);
  localparam int W = N_DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] SC = CW'(STABLE_CYCLES);
  function automatic logic [4:0] dec(input logic [6:0] p);
    case (p)
      7'b0000001: return 5'h10;
      7'b1001111: return 5'h11;
      7'b0010010: return 5'h12;
      7'b0000110: return 5'h13;
      7'b1001100: return 5'h14;
      7'b0100100: return 5'h15;
      7'b0100000: return 5'h16;
      7'b0001111, 7'b0001101, 7'b0001110: return 5'h17;
      7'b0000000: return 5'h18;
      7'b0001100, 7'b0000100: return 5'h19;
      7'b0001000, 7'b0000010: return 5'h1A;
      7'b1100000: return 5'h1B;
      7'b0110001, 7'b1110010: return 5'h1C;
      7'b1000010: return 5'h1D;
      7'b0110000, 7'b0010000: return 5'h1E;
      7'b0111000: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction
  logic [W-1:0] s0_d, s0_q, s0p_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [N_DIGITS-1:0] an, cap, seen_d, seen_q, blk_d, blk_q, inv_d, inv_q, dpr_d, dpr_q;
  logic [N_DIGITS-1:0] dpo_d, dpo_q, bo_d, bo_q, io_d, io_q;
  logic [4*N_DIGITS-1:0] dig_d, dig_q, num_d, num_q;
  logic [6:0] seg;
  logic [4:0] dv;
  logic chg, fire, done, is_blank, multi, fv_d, fv_q, err_d, err_q;
  always_comb begin
    s0_d = {SEG_ACTIVE_LOW ? segments : ~segments, SEG_ACTIVE_LOW ? dp : ~dp, ANODE_ACTIVE_LOW ? ~anodes : anodes};
    seg = s0_q[W-1 -: 7];
    an = s0_q[N_DIGITS-1:0];
    chg = s0_q != s0p_q;
    cnt_d = chg ? CW'(1) : (cnt_q == SC) ? cnt_q : cnt_q + CW'(1);
    fire = (cnt_d == SC) && (chg || cnt_q != SC);
    multi = (an & (an - 1'b1)) != '0;
    cap = (fire && an != '0 && !multi) ? an : '0;
    dv = dec(seg);
    is_blank = seg == 7'h7f;
    done = &seen_q;
    dig_d = dig_q;
    for (int i = 0; i < N_DIGITS; i++)
      dig_d[4*i +: 4] = !cap[i] ? dig_q[4*i +: 4] : dv[4] ? dv[3:0] : is_blank ? 4'h0 : dig_q[4*i +: 4];
    blk_d = (blk_q & ~cap) | (cap & {N_DIGITS{is_blank}});
    inv_d = (inv_q & ~cap) | (cap & {N_DIGITS{!dv[4] && !is_blank}});
    dpr_d = (dpr_q & ~cap) | (cap & {N_DIGITS{!s0_q[N_DIGITS]}});
    seen_d = done ? '0 : seen_q | cap;
    num_d = done ? dig_d : num_q;
    dpo_d = done ? dpr_d : dpo_q;
    bo_d = done ? blk_d : bo_q;
    io_d = done ? inv_d : io_q;
    fv_d = done;
    err_d = err_q | (fire && multi);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
      s0p_q <= '0;
      cnt_q <= '0;
      seen_q <= '0;
      dig_q <= '0;
      blk_q <= '0;
      inv_q <= '0;
      dpr_q <= '0;
      num_q <= '0;
      dpo_q <= '0;
      bo_q <= '0;
      io_q <= '0;
      fv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s0p_q <= s0_q;
      cnt_q <= cnt_d;
      seen_q <= seen_d;
      dig_q <= dig_d;
      blk_q <= blk_d;
      inv_q <= inv_d;
      dpr_q <= dpr_d;
      num_q <= num_d;
      dpo_q <= dpo_d;
      bo_q <= bo_d;
      io_q <= io_d;
      fv_q <= fv_d;
      err_q <= err_d;
    end
  end
  assign displayed_num = num_q;
  assign dp_out = dpo_q;
  assign blank = bo_q;
  assign invalid = io_q;
  assign frame_valid = fv_q;
  assign multi_anode_err = err_q;
endmodule

// File: tb/tb_sseg_frame_monitor.sv
// tb_sseg_frame_monitor: randomized and directed check of two monitor configurations against a run-length reference model
module tb_sseg_frame_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, dp_a, fv_a, err_a;
  logic [6:0] seg_a;
  logic [3:0] an_a, dpo_a, blk_a, inv_a;
  logic [15:0] num_a;
  logic rst_b, dp_b, fv_b, err_b;
  logic [6:0] seg_b;
  logic [7:0] an_b, dpo_b, blk_b, inv_b;
  logic [31:0] num_b;
  sseg_frame_monitor dut_a (
    .clk(clk), .rst(rst_a), .segments(seg_a), .dp(dp_a), .anodes(an_a),
    .displayed_num(num_a), .dp_out(dpo_a), .blank(blk_a), .invalid(inv_a),
    .frame_valid(fv_a), .multi_anode_err(err_a)
  );
  sseg_frame_monitor #(.N_DIGITS(8), .ANODE_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0), .STABLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst_b), .segments(seg_b), .dp(dp_b), .anodes(an_b),
    .displayed_num(num_b), .dp_out(dpo_b), .blank(blk_b), .invalid(inv_b),
    .frame_valid(fv_b), .multi_anode_err(err_b)
  );
  int checks = 0, errors = 0;
  int fcnt[2] = '{0, 0};
  logic [6:0] pats [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                            7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [6:0] alt_p [6] = '{7'b0001101, 7'b0001110, 7'b0000100, 7'b0000010, 7'b1110010, 7'b0010000};
  logic [3:0] alt_v [6] = '{4'h7, 4'h7, 4'h9, 4'hA, 4'hC, 4'hE};
  logic [15:0] cur [2];
  int run [2];
  logic [31:0] mdig [2], snum [2];
  logic [7:0] mblk [2], minv [2], mdpr [2], mseen [2], sdp [2], sbl [2], sinv [2];
  logic sfv [2], serr [2];
  task automatic decode(input logic [6:0] p, output bit ok, output logic [3:0] v);
    ok = 0;
    v = 4'h0;
    for (int k = 0; k < 16; k++) if (pats[k] == p) begin ok = 1; v = 4'(k); end
    for (int k = 0; k < 6; k++) if (alt_p[k] == p) begin ok = 1; v = alt_v[k]; end
  endtask
  task automatic step(input int m, input logic r, input logic [6:0] sg, input logic d, input logic [7:0] an);
    logic [7:0] full, aa, ac;
    logic [6:0] sn, cs;
    logic dn;
    logic [15:0] v;
    bit done, ok;
    logic [3:0] val;
    int s, idx;
    if (r) begin
      cur[m] = '0; run[m] = 1; mdig[m] = '0; mblk[m] = '0; minv[m] = '0; mdpr[m] = '0; mseen[m] = '0;
      snum[m] = '0; sdp[m] = '0; sbl[m] = '0; sinv[m] = '0; sfv[m] = 1'b0; serr[m] = 1'b0;
      return;
    end
    full = (m != 0) ? 8'hff : 8'h0f;
    s = (m != 0) ? 1 : 4;
    sn = (m != 0) ? ~sg : sg;
    dn = (m != 0) ? ~d : d;
    aa = (m != 0) ? an : (~an & 8'h0f);
    v = {sn, dn, aa};
    done = mseen[m] == full;
    if (run[m] == s) begin
      cs = cur[m][15:9];
      ac = cur[m][7:0];
      if ($countones(ac) == 1) begin
        idx = 0;
        for (int k = 0; k < 8; k++) if (ac[k]) idx = k;
        decode(cs, ok, val);
        if (ok) mdig[m][idx*4 +: 4] = val;
        else if (cs == 7'h7f) mdig[m][idx*4 +: 4] = 4'h0;
        mblk[m][idx] = cs == 7'h7f;
        minv[m][idx] = !ok && cs != 7'h7f;
        mdpr[m][idx] = !cur[m][8];
        mseen[m][idx] = 1'b1;
      end else if ($countones(ac) > 1) serr[m] = 1'b1;
    end
    if (done) begin
      snum[m] = mdig[m]; sdp[m] = mdpr[m]; sbl[m] = mblk[m]; sinv[m] = minv[m]; sfv[m] = 1'b1; mseen[m] = '0;
    end else sfv[m] = 1'b0;
    if (v == cur[m]) run[m]++;
    else begin cur[m] = v; run[m] = 1; end
  endtask
  always @(posedge clk) begin
    step(0, rst_a, seg_a, dp_a, {4'h0, an_a});
    step(1, rst_b, seg_b, dp_b, an_b);
  end
  always @(negedge clk) begin
    checks += 2;
    if ({num_a, dpo_a, blk_a, inv_a, fv_a, err_a} !== {snum[0][15:0], sdp[0][3:0], sbl[0][3:0], sinv[0][3:0], sfv[0], serr[0]}) begin
      errors++;
      $display("FAIL cycle_a t=%0t: got num=%h dp=%b blank=%b inv=%b fv=%b err=%b, expected num=%h dp=%b blank=%b inv=%b fv=%b err=%b",
               $time, num_a, dpo_a, blk_a, inv_a, fv_a, err_a, snum[0][15:0], sdp[0][3:0], sbl[0][3:0], sinv[0][3:0], sfv[0], serr[0]);
    end
    if ({num_b, dpo_b, blk_b, inv_b, fv_b, err_b} !== {snum[1], sdp[1], sbl[1], sinv[1], sfv[1], serr[1]}) begin
      errors++;
      $display("FAIL cycle_b t=%0t: got num=%h dp=%b blank=%b inv=%b fv=%b err=%b, expected num=%h dp=%b blank=%b inv=%b fv=%b err=%b",
               $time, num_b, dpo_b, blk_b, inv_b, fv_b, err_b, snum[1], sdp[1], sbl[1], sinv[1], sfv[1], serr[1]);
    end
    if (fv_a) fcnt[0]++;
    if (fv_b) fcnt[1]++;
  end
  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic show_a(input logic [6:0] p, input logic lit_dp, input int d, input int n);
    seg_a = p;
    dp_a = !lit_dp;
    an_a = ~(4'b0001 << d);
    wait_cycles(n);
  endtask
  task automatic show_b(input logic [6:0] p, input logic lit_dp, input int d, input int n);
    seg_b = ~p;
    dp_b = lit_dp;
    an_b = 8'b1 << d;
    wait_cycles(n);
  endtask
  task automatic idle_a(input int n);
    an_a = 4'hf;
    wait_cycles(n);
  endtask
  task automatic idle_b(input int n);
    an_b = 8'h00;
    wait_cycles(n);
  endtask
  function automatic logic [6:0] pick();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return pats[$urandom_range(0, 15)];
    if (r == 6) return alt_p[$urandom_range(0, 5)];
    if (r == 7) return 7'h7f;
    return 7'($urandom);
  endfunction
  task automatic rand_a();
    int k, h;
    for (int it = 0; it < 250; it++) begin
      k = $urandom_range(0, 99);
      h = $urandom_range(1, 9);
      if (k < 2) begin
        rst_a = 1'b1;
        wait_cycles(2);
        rst_a = 1'b0;
      end else if (k < 5) begin
        seg_a = pick();
        dp_a = 1'($urandom);
        an_a = ~(4'b0011 << $urandom_range(0, 2));
        wait_cycles(h);
      end else if (k < 10) idle_a(h);
      else show_a(pick(), 1'($urandom), $urandom_range(0, 3), h);
    end
  endtask
  task automatic rand_b();
    int k, h;
    for (int it = 0; it < 250; it++) begin
      k = $urandom_range(0, 99);
      h = $urandom_range(1, 4);
      if (k < 2) begin
        rst_b = 1'b1;
        wait_cycles(2);
        rst_b = 1'b0;
      end else if (k < 5) begin
        seg_b = ~pick();
        dp_b = 1'($urandom);
        an_b = 8'b11 << $urandom_range(0, 6);
        wait_cycles(h);
      end else if (k < 10) idle_b(h);
      else show_b(pick(), 1'($urandom), $urandom_range(0, 7), h);
    end
  endtask
  initial begin
    int f;
    rst_a = 1'b1; seg_a = 7'h7f; dp_a = 1'b1; an_a = 4'hf;
    rst_b = 1'b1; seg_b = 7'h00; dp_b = 1'b0; an_b = 8'h00;
    wait_cycles(3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    lit("reset_num_a", 32'(num_a), 32'h0);
    lit("reset_flags_a", {20'h0, dpo_a, blk_a, inv_a}, 32'h0);
    lit("reset_err_a", 32'(err_a), 32'h0);
    lit("reset_num_b", num_b, 32'h0);
    f = fcnt[0];
    show_a(pats[4], 1'b0, 0, 8);
    show_a(pats[3], 1'b0, 1, 8);
    show_a(pats[2], 1'b0, 2, 8);
    show_a(pats[1], 1'b0, 3, 8);
    idle_a(8);
    lit("basic_frames", 32'(fcnt[0] - f), 32'd1);
    lit("basic_num", 32'(num_a), 32'h1234);
    lit("basic_blank", 32'(blk_a), 32'h0);
    lit("basic_invalid", 32'(inv_a), 32'h0);
    show_a(pats[5], 1'b0, 0, 8);
    show_a(pats[6], 1'b0, 1, 8);
    show_a(pats[8], 1'b0, 1, 2);
    show_a(pats[6], 1'b0, 1, 8);
    show_a(pats[7], 1'b0, 2, 8);
    show_a(pats[9], 1'b0, 3, 8);
    idle_a(8);
    lit("glitch_num", 32'(num_a), 32'h9765);
    show_a(pats[0], 1'b0, 0, 8);
    show_a(pats[1], 1'b0, 1, 8);
    show_a(pats[5], 1'b0, 2, 8);
    show_a(7'b1111110, 1'b0, 2, 8);
    show_a(7'h7f, 1'b1, 3, 8);
    idle_a(8);
    lit("inv_num", 32'(num_a), 32'h0510);
    lit("inv_invalid", 32'(inv_a), 32'h4);
    lit("inv_blank", 32'(blk_a), 32'h8);
    lit("inv_dp", 32'(dpo_a), 32'h8);
    seg_a = pats[8];
    an_a = 4'b1100;
    wait_cycles(8);
    idle_a(4);
    lit("multi_err", 32'(err_a), 32'h1);
    lit("multi_num", 32'(num_a), 32'h0510);
    show_a(pats[1], 1'b0, 0, 8);
    idle_a(4);
    lit("multi_sticky", 32'(err_a), 32'h1);
    rst_a = 1'b1;
    wait_cycles(2);
    rst_a = 1'b0;
    lit("multi_rst_err", 32'(err_a), 32'h0);
    lit("multi_rst_num", 32'(num_a), 32'h0);
    show_a(7'b0000100, 1'b0, 0, 8);
    show_a(7'b1110010, 1'b0, 1, 8);
    show_a(7'b0001101, 1'b0, 2, 8);
    show_a(pats[0], 1'b0, 3, 8);
    idle_a(8);
    lit("alt_num", 32'(num_a), 32'h07C9);
    for (int k = 0; k < 5; k++) show_b(pats[k], 1'b0, k, 2);
    rst_b = 1'b1;
    wait_cycles(2);
    rst_b = 1'b0;
    f = fcnt[1];
    for (int k = 0; k < 8; k++) show_b(pats[k], 1'b0, k, 2);
    idle_b(4);
    lit("wide_frames", 32'(fcnt[1] - f), 32'd1);
    lit("wide_num", num_b, 32'h76543210);
    fork
      rand_a();
      rand_b();
    join
    idle_a(10);
    idle_b(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
